key_filter: RTL and testbench
=============================

# key_filter

Debounces a raw mechanical push-button and turns it into clean control signals for downstream logic such as the LED toggle flip-flop. It is the producing end of the key interface: the key input that the flip-flop consumes comes from here, not straight from the pin. It synchronises the asynchronous pin and requires the level to be stable for a programmable window. It then emits a debounced level plus one-cycle press and release pulses.

## Interface
- CNT_MAX, default 999_999: stable-window length minus one, in sys_clk cycles (20 ms at 50 MHz); must be ≥ 1.
- KEY_ACTIVE, default 1'b0: pin level that means "pressed"; boards use active-low keys.
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- key_in  input  1  raw key pin, asynchronous, bouncing.
- key_state  output  1  debounced level, 1 = pressed.
- key_flag  output  1  one-cycle pulse on confirmed press.
- key_release  output  1  one-cycle pulse on confirmed release.

## Operation
- key_in passes through a 2-FF synchroniser; key_s is the second stage, normalised so 1 = active (key_in == KEY_ACTIVE).
- Counter width is $clog2(CNT_MAX+1); it never wraps.
- FSM states and transitions:
  - IDLE: when key_s = 1, go to PRESS_WAIT with cnt = 0.
  - PRESS_WAIT: when key_s = 0, go to IDLE with cnt = 0 (bounce rejected, no pulse). Else when cnt == CNT_MAX, go to PRESSED; key_flag = 1 for that one cycle and key_state = 1. Else cnt++.
  - PRESSED: when key_s = 0, go to RELEASE_WAIT with cnt = 0.
  - RELEASE_WAIT: when key_s = 1, go back to PRESSED with cnt = 0 and no pulse. Else when cnt == CNT_MAX, go to IDLE; key_release = 1 for one cycle and key_state = 0. Else cnt++.
- key_flag and key_release are registered, are never high together, and stay low for at least CNT_MAX+1 cycles between them.
- The counter is not used in IDLE or PRESSED and is held at 0 there.

## Timing
- Reset applies at a sys_clk edge while sys_rst = 1:
  - both synchroniser stages load !KEY_ACTIVE;
  - state goes to IDLE and cnt to 0;
  - key_state, key_flag and key_release go to 0.
- Reset asserted mid-window aborts the window: no pulse is emitted, and key_state goes to 0 even if the key was in PRESSED.
- Press latency: key_in becomes active before edge k and stays stable.
  - Sync stage 1 captures at edge k; key_s is valid at edge k+1.
  - PRESS_WAIT is entered at edge k+2.
  - key_flag and key_state rise at edge k+CNT_MAX+3; key_flag falls one edge later.
- Release latency is identical: key_release rises and key_state falls at edge k+CNT_MAX+3.
- Any glitch on key_s during a wait state restarts the full window. Worst-case detection is therefore unbounded under continuous bounce, which is the intended behaviour.
- A bounce shorter than 1 cycle may be missed by the synchroniser. This is acceptable.

## Structure
- The state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3) goes in shared package key_pkg, so benches can probe the state by name.
- One sub-module, key_sync: a 2-FF synchroniser with parameter RESET_VAL and a synchronous active-high reset. It is reused by later pin-input blocks.
- key_filter holds the FSM, the counter and the output registers. It has no other hierarchy.

## Test plan
All scenarios use CNT_MAX = 9, KEY_ACTIVE = 0 and a 20 ns clock.
- Clean press:
  - Stimulus: key_in goes 1→0 just before edge k and is held.
  - Required: key_flag = 1 exactly in the cycle after edge k+12; key_state = 1 from edge k+12; no key_release.
- Clean release after a press:
  - Stimulus: key_in goes 0→1 and is held.
  - Required: key_release is a single 1-cycle pulse 12 edges later; key_state = 0 from the same edge.
- Bounce rejection:
  - Stimulus: from IDLE, key_in toggles with random dwell of 1–8 cycles for 200 ns, then returns to 1.
  - Required: key_flag, key_release and key_state stay 0 throughout.
- Bounce then settle:
  - Stimulus: the same random toggling, then key_in held at 0.
  - Required: exactly one key_flag pulse, 12 edges after the last 1→0 transition.
- Reset mid-operation:
  - Stimulus: assert sys_rst for 1 cycle while in PRESS_WAIT with cnt = 5, and separately while in PRESSED.
  - Required: all outputs 0 at the next edge and no pulse afterwards. A key still held at 0 then needs a fresh full window: key_flag 12 edges after reset deasserts.
- Random soak:
  - Stimulus: key_in ← $random % 2 every 20 ns for 10 µs, followed by long holds.
  - Required: the scoreboard confirms pulses strictly alternate flag/release, never coincide, and always match the reference-model edge counts.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and counter sizing.
// Benches import this package to probe the filter state by name.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_e;

  // Bits needed to count 0..cnt_max; never below one bit.
  function automatic int cnt_width(input int cnt_max);
    return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous pin input.
// RESET_VAL lets each pin reset to its own idle level.
module key_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: synchronised key level must stay stable for CNT_MAX+1
// cycles before the debounced state flips and a one-cycle press/release pulse fires.
module key_filter
  import key_pkg::*;
#(
  parameter int   CNT_MAX    = 999_999,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic key_release
);

  localparam int             CW       = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX);

  logic          key_sync_q;
  logic          key_s;
  key_fsm_e      state_reg;
  logic [CW-1:0] cnt_reg;
  logic          key_state_reg;
  logic          key_flag_reg;
  logic          key_release_reg;

  key_sync #(
    .RESET_VAL (~KEY_ACTIVE)
  ) u_key_sync (
    .clk  (sys_clk),
    .srst (sys_rst),
    .d    (key_in),
    .q    (key_sync_q)
  );

  // Normalise polarity so the FSM only ever deals with 1 = pressed.
  assign key_s = (key_sync_q == KEY_ACTIVE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      key_state_reg   <= 1'b0;
      key_flag_reg    <= 1'b0;
      key_release_reg <= 1'b0;
    end else begin
      key_flag_reg    <= 1'b0;
      key_release_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (key_s) state_reg <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!key_s) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg     <= PRESSED;
            cnt_reg       <= '0;
            key_flag_reg  <= 1'b1;
            key_state_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        PRESSED: begin
          cnt_reg <= '0;
          if (!key_s) state_reg <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          // Any return to the pressed level restarts the whole release window.
          if (key_s) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            key_release_reg <= 1'b1;
            key_state_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign key_state   = key_state_reg;
  assign key_flag    = key_flag_reg;
  assign key_release = key_release_reg;

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter (CNT_MAX = 9, active-low key, 20 ns clock).
// Reference model: debounced level flips once the pipelined key level has disagreed with it for CNT_MAX+2 edges.
module tb_key_filter;
  import key_pkg::*;

  localparam int   CNT_MAX    = 9;
  localparam logic KEY_ACTIVE = 1'b0;
  localparam int   LAT        = CNT_MAX + 3;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_state, key_flag, key_release;

  int n_cmp = 0;
  int n_err = 0;
  int n_flag_seen = 0;
  int n_rel_seen = 0;
  bit last_flag = 1'b0;

  // model state
  bit act1 = 1'b0, act2 = 1'b0, deb = 1'b0, m_flag = 1'b0, m_rel = 1'b0;
  int run = 0;

  key_filter #(
    .CNT_MAX    (CNT_MAX),
    .KEY_ACTIVE (KEY_ACTIVE)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_flag    (key_flag),
    .key_release (key_release)
  );

  always #10 sys_clk = ~sys_clk;

  // The FSM at edge n acts on the pin level seen two edges earlier (act2).
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      act1 = 1'b0; act2 = 1'b0; deb = 1'b0; run = 0;
      m_flag = 1'b0; m_rel = 1'b0;
    end else begin
      m_flag = 1'b0; m_rel = 1'b0;
      if (act2 != deb) begin
        run++;
        if (run == CNT_MAX + 2) begin
          deb = act2;
          run = 0;
          if (deb) m_flag = 1'b1; else m_rel = 1'b1;
        end
      end else begin
        run = 0;
      end
      act2 = act1;
      act1 = (key_in == KEY_ACTIVE);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: wait for the falling edge, then check outputs against the model.
  task automatic tick();
    @(negedge sys_clk);
    chk("state_vs_model", {31'd0, key_state}, {31'd0, deb});
    chk("flag_vs_model", {31'd0, key_flag}, {31'd0, m_flag});
    chk("release_vs_model", {31'd0, key_release}, {31'd0, m_rel});
    chk("no_coincide", {31'd0, key_flag & key_release}, 32'd0);
    if (key_flag === 1'b1) begin
      chk("alt_flag", {31'd0, last_flag}, 32'd0);
      last_flag = 1'b1;
      n_flag_seen++;
    end
    if (key_release === 1'b1) begin
      chk("alt_release", {31'd0, last_flag}, 32'd1);
      last_flag = 1'b0;
      n_rel_seen++;
    end
  endtask

  // key_in was just changed ahead of edge k; find the pulse edge relative to k.
  task automatic measure(input string tag, input bit want_flag);
    int first = -1;
    int n_want = 0;
    int n_other = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((want_flag ? key_flag : key_release) === 1'b1) begin
        if (first < 0) first = i;
        n_want++;
      end
      if ((want_flag ? key_release : key_flag) === 1'b1) n_other++;
    end
    chk({tag, "_edge"}, first, LAT);
    chk({tag, "_count"}, n_want, 1);
    chk({tag, "_other"}, n_other, 0);
    chk({tag, "_state"}, {31'd0, key_state}, {31'd0, want_flag});
    $display("%s: pulse at edge k+%0d, pulses=%0d, other=%0d, key_state=%0b",
             tag, first, n_want, n_other, key_state);
  endtask

  task automatic bounce(input int cycles);
    int elapsed = 0;
    while (elapsed < cycles) begin
      int dwell = $urandom_range(1, 8);
      key_in = ~key_in;
      repeat (dwell) tick();
      elapsed += dwell;
    end
  endtask

  task automatic pulse_reset(input string tag);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk({tag, "_state"}, {31'd0, key_state}, 32'd0);
    chk({tag, "_flag"}, {31'd0, key_flag}, 32'd0);
    chk({tag, "_release"}, {31'd0, key_release}, 32'd0);
    chk({tag, "_fsm_idle"}, {30'd0, dut.state_reg}, {30'd0, IDLE});
    last_flag = 1'b0;
    $display("%s: outputs after reset state=%0b flag=%0b release=%0b",
             tag, key_state, key_flag, key_release);
  endtask

  initial begin
    int f0, r0;
    sys_rst = 1'b1;
    key_in  = 1'b1;
    tick();
    tick();
    chk("reset_state", {31'd0, key_state}, 32'd0);
    chk("reset_flag", {31'd0, key_flag}, 32'd0);
    chk("reset_release", {31'd0, key_release}, 32'd0);
    chk("reset_fsm", {30'd0, dut.state_reg}, {30'd0, IDLE});
    sys_rst = 1'b0;
    repeat (3) tick();
    $display("reset: key_state=%0b key_flag=%0b key_release=%0b", key_state, key_flag, key_release);

    key_in = 1'b0;
    measure("clean_press", 1'b1);
    key_in = 1'b1;
    measure("clean_release", 1'b0);

    f0 = n_flag_seen; r0 = n_rel_seen;
    bounce(10);
    key_in = 1'b1;
    repeat (20) tick();
    chk("bounce_no_flag", n_flag_seen - f0, 0);
    chk("bounce_no_release", n_rel_seen - r0, 0);
    chk("bounce_state", {31'd0, key_state}, 32'd0);
    $display("bounce_reject: flags=%0d releases=%0d key_state=%0b",
             n_flag_seen - f0, n_rel_seen - r0, key_state);

    bounce(10);
    key_in = 1'b1;
    tick();
    key_in = 1'b0;
    measure("bounce_settle", 1'b1);
    key_in = 1'b1;
    measure("bounce_settle_release", 1'b0);

    // Reset while PRESS_WAIT holds cnt = 5: state entered at k+2, cnt 5 after k+7.
    key_in = 1'b0;
    repeat (8) tick();
    chk("mid_wait_fsm", {30'd0, dut.state_reg}, {30'd0, PRESS_WAIT});
    chk("mid_wait_cnt", {28'd0, dut.cnt_reg}, 32'd5);
    pulse_reset("reset_in_wait");
    measure("press_after_wait_reset", 1'b1);

    repeat (5) tick();
    pulse_reset("reset_in_pressed");
    measure("press_after_pressed_reset", 1'b1);
    key_in = 1'b1;
    measure("release_after_resets", 1'b0);

    f0 = n_flag_seen; r0 = n_rel_seen;
    for (int i = 0; i < 500; i++) begin
      key_in = 1'($urandom % 2);
      tick();
    end
    for (int h = 0; h < 4; h++) begin
      key_in = h[0];
      repeat (30) tick();
    end
    chk("soak_balance", n_flag_seen - f0, n_rel_seen - r0);
    chk("soak_final_state", {31'd0, key_state}, 32'd0);
    $display("random_soak: flags=%0d releases=%0d final key_state=%0b",
             n_flag_seen - f0, n_rel_seen - r0, key_state);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
